// File: rtl/bram_bilinear_rd.sv
// bram_bilinear_rd: DDA-driven read controller returning bilinear neighbours from a parity-split line-buffer BRAM pair
module bram_bilinear_rd #(
   parameter int SRC_W = 640,
   parameter int SRC_H = 480,
   parameter int DST_W = 1920
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_line_start,
   input  logic [9:0]  i_src_y,
   input  logic [7:0]  i_fy,
   input  logic [16:0] i_x_step,
   output logic        o_busy,
   output logic [11:0] o_ch0_raddr,
   output logic [11:0] o_ch1_raddr,
   output logic        o_bram_re,
   input  logic [31:0] i_ch0_rdata,
   input  logic [31:0] i_ch1_rdata,
   input  logic        i_bram_rvld,
   output logic [31:0] o_p00,
   output logic [31:0] o_p01,
   output logic [31:0] o_p10,
   output logic [31:0] o_p11,
   output logic [7:0]  o_fx,
   output logic [7:0]  o_fy,
   output logic        o_pix_vld,
   output logic        o_line_done
);
   localparam int CW = $clog2(DST_W);
   typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B} state_t;
   state_t r_state, w_next;
   logic [9:0]  r_y;
   logic [7:0]  r_fy;
   logic [16:0] r_step;
   logic [27:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic        r_busy, r_tag_b, r_tag_y0, r_tag_y1, r_tag_last;
   logic [7:0]  r_tag_fx;
   logic [31:0] r_a_top, r_a_bot;
   logic [9:0]  w_y1, w_x0, w_x1, w_col;
   logic [1:0]  w_rid0, w_rid1;
   logic [31:0] w_top, w_bot;
   logic        w_start, w_last, w_pix;
   // acc carries 12 integer bits so DST_W steps of up to 2.0 never wrap before the column clamp
   assign w_y1    = (r_y >= 10'(SRC_H - 1)) ? r_y : r_y + 10'd1;
   assign w_x0    = (r_acc[27:16] > 12'(SRC_W - 1)) ? 10'(SRC_W - 1) : r_acc[25:16];
   assign w_x1    = (w_x0 >= 10'(SRC_W - 1)) ? w_x0 : w_x0 + 10'd1;
   assign w_col   = (r_state == FETCH_B) ? w_x1 : w_x0;
   assign w_rid0  = r_y[0] ? w_y1[2:1] : r_y[2:1];
   assign w_rid1  = r_y[0] ? r_y[2:1] : w_y1[2:1];
   assign w_start = i_line_start & ~r_busy;
   assign w_last  = r_cnt == CW'(DST_W - 1);
   assign o_bram_re   = r_state != IDLE;
   assign o_ch0_raddr = o_bram_re ? {w_rid0, w_col} : 12'd0;
   assign o_ch1_raddr = o_bram_re ? {w_rid1, w_col} : 12'd0;
   assign o_busy      = r_busy;
   assign w_top = r_tag_y0 ? i_ch1_rdata : i_ch0_rdata;
   assign w_bot = r_tag_y1 ? i_ch1_rdata : i_ch0_rdata;
   assign w_pix = i_bram_rvld & r_tag_b;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   // next state: two fetches per output pixel until the line count is reached
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE)    ? (w_start ? FETCH_A : IDLE) :
               (r_state == FETCH_A) ? FETCH_B :
               (w_last ? IDLE : FETCH_A);
   end
   // line parameters, DDA accumulator and pixel counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_y <= '0; r_fy <= '0; r_step <= '0; r_acc <= '0; r_cnt <= '0; r_busy <= 1'b0;
      end else begin
         if (w_start) begin
            r_y <= i_src_y; r_fy <= i_fy; r_step <= i_x_step; r_acc <= '0; r_cnt <= '0;
         end else if (r_state == FETCH_B) begin
            r_acc <= r_acc + 28'(r_step);
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_start) r_busy <= 1'b1;
         else if (o_line_done) r_busy <= 1'b0;
      end
   // tag travelling alongside each read so returning data can be steered
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_tag_b <= 1'b0; r_tag_y0 <= 1'b0; r_tag_y1 <= 1'b0; r_tag_last <= 1'b0; r_tag_fx <= '0;
      end else begin
         r_tag_b    <= r_state == FETCH_B;
         r_tag_y0   <= r_y[0];
         r_tag_y1   <= w_y1[0];
         r_tag_last <= (r_state == FETCH_B) & w_last;
         r_tag_fx   <= r_acc[15:8];
      end
   // stage x0 column data, then publish the full neighbourhood on the x1 return
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_a_top <= '0; r_a_bot <= '0; o_p00 <= '0; o_p01 <= '0; o_p10 <= '0; o_p11 <= '0;
         o_fx <= '0; o_fy <= '0; o_pix_vld <= 1'b0; o_line_done <= 1'b0;
      end else begin
         if (i_bram_rvld & ~r_tag_b) begin
            r_a_top <= w_top;
            r_a_bot <= w_bot;
         end
         if (w_pix) begin
            o_p00 <= r_a_top; o_p01 <= w_top; o_p10 <= r_a_bot; o_p11 <= w_bot;
            o_fx  <= r_tag_fx; o_fy <= r_fy;
         end
         o_pix_vld   <= w_pix;
         o_line_done <= w_pix & r_tag_last;
      end
endmodule
